fb_scanout_reader: RTL and testbench



---
 rtl/fb_scanout_reader_pkg.sv | 65 ++++++
 rtl/fb_scanout_reader_vga_timing_gen.sv | 68 ++++++
 rtl/fb_scanout_reader.sv | 206 ++++++++++++++++++++
 tb/tb_fb_scanout_reader.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fb_scanout_reader_pkg.sv
// Shared constants for the framebuffer: VGA 640x480@60 timing, pixel word
// layout and framebuffer geometry. The GPU write side imports this too.
package fb_scanout_reader_pkg;

    // VGA 640x480@60 timing at a 25 MHz pixel clock
    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_H_FP     = 16;
    localparam int VGA_H_SYNC   = 96;
    localparam int VGA_H_BP     = 48;
    localparam int VGA_H_TOTAL  = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;

    localparam int VGA_V_ACTIVE = 480;
    localparam int VGA_V_FP     = 10;
    localparam int VGA_V_SYNC   = 2;
    localparam int VGA_V_BP     = 33;
    localparam int VGA_V_TOTAL  = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

    // Framebuffer geometry: 640x400, one 16-bit word per pixel, row-major
    localparam int FB_LINES      = 400;
    localparam int FB_STRIDE     = VGA_H_ACTIVE;
    localparam int FB_BASE_ADDR  = 0;
    localparam int FB_RD_LATENCY = 1;

    localparam int ADDR_W = 18;
    localparam int DATA_W = 16;
    localparam int DAC_W  = 10;
    // Wide enough for both 800 and 525
    localparam int CNT_W  = 10;

    // Pixel word fields
    localparam int DEPTH_HI = 15;
    localparam int DEPTH_LO = 14;
    localparam int R_HI     = 11;
    localparam int R_LO     = 8;
    localparam int G_HI     = 7;
    localparam int G_LO     = 4;
    localparam int B_HI     = 3;
    localparam int B_LO     = 0;

    // Word the GPU clears to: farthest depth, black
    localparam logic [DATA_W-1:0] FB_CLEAR_WORD = 16'hC000;

    // Per-pixel control carried alongside the SRAM read
    typedef struct packed {
        logic hs;
        logic vs;
        logic blank_n;
        logic frame_start;
        logic fetch;
    } pix_ctl_t;

    localparam pix_ctl_t CTL_IDLE = '{hs: 1'b1, vs: 1'b1, blank_n: 1'b0,
                                      frame_start: 1'b0, fetch: 1'b0};

    // 4-bit channel to 10-bit DAC code, full scale maps to full scale
    function automatic logic [DAC_W-1:0] expand_color(input logic [3:0] c);
        return {c, c, c[3:2]};
    endfunction

    // 2-bit depth to a 10-bit gray level
    function automatic logic [DAC_W-1:0] expand_depth(input logic [1:0] d);
        return {d, d, d, d, d};
    endfunction

endpackage

// File: rtl/fb_scanout_reader_vga_timing_gen.sv
// Horizontal/vertical raster counters and the raw, undelayed per-pixel
// flags derived from them (sync, active, fetch window, frame tick).
module vga_timing_gen
    import fb_scanout_reader_pkg::*;
#(
    parameter int H_ACTIVE = VGA_H_ACTIVE,
    parameter int H_FP     = VGA_H_FP,
    parameter int H_SYNC   = VGA_H_SYNC,
    parameter int H_BP     = VGA_H_BP,
    parameter int V_ACTIVE = VGA_V_ACTIVE,
    parameter int V_FP     = VGA_V_FP,
    parameter int V_SYNC   = VGA_V_SYNC,
    parameter int V_BP     = VGA_V_BP,
    parameter int FB_ROWS  = FB_LINES
) (
    input  logic clk_i,
    input  logic rst_ni,
    output logic hs_o,
    output logic vs_o,
    output logic active_o,
    output logic fetch_o,
    output logic frame_tick_o
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_ACT_C  = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT_C  = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] FB_ROW_C = CNT_W'(FB_ROWS);
    localparam logic [CNT_W-1:0] HS_ON    = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_OFF   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] VS_ON    = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_OFF   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

    logic [CNT_W-1:0] h_q, h_d;
    logic [CNT_W-1:0] v_q, v_d;

    // Next raster position: h wraps each line, v advances on h wrap
    always_comb begin
        h_d = h_q + 1'b1;
        v_d = v_q;
        if (h_q == H_LAST) begin
            h_d = '0;
            v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
        end
    end

    // Raster counters
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            h_q <= '0;
            v_q <= '0;
        end else begin
            h_q <= h_d;
            v_q <= v_d;
        end
    end

    assign hs_o         = !((h_q >= HS_ON) && (h_q < HS_OFF));
    assign vs_o         = !((v_q >= VS_ON) && (v_q < VS_OFF));
    assign active_o     = (h_q < H_ACT_C) && (v_q < V_ACT_C);
    assign fetch_o      = (h_q < H_ACT_C) && (v_q < FB_ROW_C);
    assign frame_tick_o = (h_q == '0) && (v_q == '0);

endmodule

// File: rtl/fb_scanout_reader.sv
// Display-side framebuffer reader. Issues one SRAM read per fetched pixel,
// holds SRAM ownership while reads are outstanding, and delays the raster
// control by the SRAM read latency so sync/blank line up with the pixel data.
//
// SRAM handshake: oMEM_READ is a one-cycle strobe with oMEM_ADDR; the word
// for that address is sampled from iMEM_DATA exactly RD_LATENCY clock edges
// later. There is no backpressure. The GPU may drive the SRAM only while
// oVIDEO_ON is 0.
module fb_scanout_reader
    import fb_scanout_reader_pkg::*;
#(
    parameter int H_ACTIVE   = VGA_H_ACTIVE,
    parameter int H_FP       = VGA_H_FP,
    parameter int H_SYNC     = VGA_H_SYNC,
    parameter int H_BP       = VGA_H_BP,
    parameter int V_ACTIVE   = VGA_V_ACTIVE,
    parameter int V_FP       = VGA_V_FP,
    parameter int V_SYNC     = VGA_V_SYNC,
    parameter int V_BP       = VGA_V_BP,
    parameter int FB_ROWS    = FB_LINES,
    parameter int FB_BASE    = FB_BASE_ADDR,
    parameter int RD_LATENCY = FB_RD_LATENCY   // 1..3
) (
    input  logic              iCLK,
    input  logic              iRST_N,
    input  logic [DATA_W-1:0] iMEM_DATA,
    input  logic              iSHOW_DEPTH,
    output logic [ADDR_W-1:0] oMEM_ADDR,
    output logic              oMEM_READ,
    output logic              oVIDEO_ON,
    output logic [DAC_W-1:0]  oVGA_R,
    output logic [DAC_W-1:0]  oVGA_G,
    output logic [DAC_W-1:0]  oVGA_B,
    output logic              oVGA_HS,
    output logic              oVGA_VS,
    output logic              oVGA_BLANK_N,
    output logic              oFRAME_START
);

    localparam logic [ADDR_W-1:0] BASE_A  = ADDR_W'(FB_BASE);
    localparam logic [1:0]        LAT_CNT = 2'(RD_LATENCY);

    logic raw_hs, raw_vs, raw_active, raw_fetch, raw_tick;

    vga_timing_gen #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP),
        .FB_ROWS  (FB_ROWS)
    ) u_timing (
        .clk_i        (iCLK),
        .rst_ni       (iRST_N),
        .hs_o         (raw_hs),
        .vs_o         (raw_vs),
        .active_o     (raw_active),
        .fetch_o      (raw_fetch),
        .frame_tick_o (raw_tick)
    );

    // ---------------- SRAM address generation ----------------
    logic [ADDR_W-1:0] mem_addr_q, next_addr_q, addr_d;
    logic              mem_read_q;

    // Rows are contiguous (stride == line width), so a running counter
    // reloaded at pixel (0,0) walks the whole framebuffer.
    always_comb addr_d = raw_tick ? BASE_A : next_addr_q;

    // Read strobe and address; address holds outside the fetch window
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            mem_read_q  <= 1'b0;
            mem_addr_q  <= '0;
            next_addr_q <= BASE_A;
        end else begin
            mem_read_q <= raw_fetch;
            if (raw_fetch) begin
                mem_addr_q  <= addr_d;
                next_addr_q <= addr_d + 1'b1;
            end
        end
    end

    // ---------------- SRAM ownership ----------------
    logic [1:0] own_cnt_q;
    logic       video_on_q;

    // Ownership starts with a line's first read and ends RD_LATENCY
    // cycles after its last one, covering reads still in flight.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            own_cnt_q  <= '0;
            video_on_q <= 1'b0;
        end else if (raw_fetch) begin
            own_cnt_q  <= LAT_CNT;
            video_on_q <= 1'b1;
        end else begin
            video_on_q <= (own_cnt_q > 2'd1);
            if (own_cnt_q != 2'd0) begin
                own_cnt_q <= own_cnt_q - 2'd1;
            end
        end
    end

    // ---------------- Display mode ----------------
    logic show_depth_q;

    // Mode only changes at the start of a frame so a frame never tears
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            show_depth_q <= 1'b0;
        end else if (raw_tick) begin
            show_depth_q <= iSHOW_DEPTH;
        end
    end

    // ---------------- Control delay pipe ----------------
    pix_ctl_t ctl_raw;
    pix_ctl_t ctl_out;
    pix_ctl_t pipe_q [RD_LATENCY];

    always_comb begin
        ctl_raw = '{hs: raw_hs, vs: raw_vs, blank_n: raw_active,
                    frame_start: raw_tick, fetch: raw_fetch};
    end

    // Delay raster control to match the SRAM read latency
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            for (int i = 0; i < RD_LATENCY; i++) begin
                pipe_q[i] <= CTL_IDLE;
            end
        end else begin
            pipe_q[0] <= ctl_raw;
            for (int i = 1; i < RD_LATENCY; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    assign ctl_out = pipe_q[RD_LATENCY-1];

    // ---------------- Pixel unpack ----------------
    logic [DAC_W-1:0] r_d, g_d, b_d;
    logic [DAC_W-1:0] vga_r_q, vga_g_q, vga_b_q;
    logic             hs_q, vs_q, blank_n_q, frame_start_q;
    logic [1:0]       unused_bits;

    assign unused_bits = iMEM_DATA[13:12];

    // Fetched pixels are shown as color or depth gray; letterbox and
    // blanking are black.
    always_comb begin
        r_d = '0;
        g_d = '0;
        b_d = '0;
        if (ctl_out.fetch) begin
            if (show_depth_q) begin
                r_d = expand_depth(iMEM_DATA[DEPTH_HI:DEPTH_LO]);
                g_d = r_d;
                b_d = r_d;
            end else begin
                r_d = expand_color(iMEM_DATA[R_HI:R_LO]);
                g_d = expand_color(iMEM_DATA[G_HI:G_LO]);
                b_d = expand_color(iMEM_DATA[B_HI:B_LO]);
            end
        end
    end

    // Registered VGA outputs, all aligned to the same pixel
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            vga_r_q       <= '0;
            vga_g_q       <= '0;
            vga_b_q       <= '0;
            hs_q          <= 1'b1;
            vs_q          <= 1'b1;
            blank_n_q     <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            vga_r_q       <= r_d;
            vga_g_q       <= g_d;
            vga_b_q       <= b_d;
            hs_q          <= ctl_out.hs;
            vs_q          <= ctl_out.vs;
            blank_n_q     <= ctl_out.blank_n;
            frame_start_q <= ctl_out.frame_start;
        end
    end

    assign oMEM_ADDR    = mem_addr_q;
    assign oMEM_READ    = mem_read_q;
    assign oVIDEO_ON    = video_on_q;
    assign oVGA_R       = vga_r_q;
    assign oVGA_G       = vga_g_q;
    assign oVGA_B       = vga_b_q;
    assign oVGA_HS      = hs_q;
    assign oVGA_VS      = vs_q;
    assign oVGA_BLANK_N = blank_n_q;
    assign oFRAME_START = frame_start_q;

endmodule

// File: tb/tb_fb_scanout_reader.sv
// Bench for fb_scanout_reader. Two instances (read latency 1 and 3) run in
// lockstep on a shrunk raster so several whole frames fit in a short run.
module tb_fb_scanout_reader;

    // Shrunk geometry: 25x17 raster, 16x8 framebuffer
    localparam int H_ACT = 16, H_FP = 2, H_SYNC = 4, H_BP = 3;
    localparam int V_ACT = 12, V_FP = 1, V_SYNC = 2, V_BP = 2;
    localparam int H_TOT = H_ACT + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_ACT + V_FP + V_SYNC + V_BP;
    localparam int FB_R  = 8;
    localparam int BASE1 = 0;
    localparam int BASE3 = 100;
    localparam int W     = 34;

    localparam logic [W-1:0]  PIX_IDLE = {30'd0, 1'b1, 1'b1, 1'b0, 1'b0};
    localparam logic [53:0]   RST_VEC  = {1'b0, 18'd0, 1'b0, 30'd0, 1'b1, 1'b1, 1'b0, 1'b0};

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic show_depth = 1'b0;
    logic data_mode = 1'b0;   // 0 = address pattern, 1 = all FB_CLEAR words

    initial forever #5 clk = ~clk;

    // ---------------- DUTs and SRAM models ----------------
    logic [15:0] mem_data1, mem_data3;
    logic [17:0] addr1, addr3, a3_d1, a3_d2;
    logic        read1, read3, von1, von3;
    logic [9:0]  r1, g1, b1, r3, g3, b3;
    logic        hs1, vs1, bn1, fs1, hs3, vs3, bn3, fs3;
    logic [53:0] all1, all3;

    function automatic logic [15:0] mem_word(input logic [17:0] a, input logic mode);
        logic [31:0] x;
        if (mode) return 16'hC000;
        if (a == 18'd5) return 16'h0A5C;
        x = {14'd0, a} * 32'd40503 + 32'h00005A3C;
        return x[15:0];
    endfunction

    always_comb mem_data1 = mem_word(addr1, data_mode);
    always @(posedge clk) begin
        a3_d1 <= addr3;
        a3_d2 <= a3_d1;
    end
    always_comb mem_data3 = mem_word(a3_d2, data_mode);

    assign all1 = {read1, addr1, von1, r1, g1, b1, hs1, vs1, bn1, fs1};
    assign all3 = {read3, addr3, von3, r3, g3, b3, hs3, vs3, bn3, fs3};

    fb_scanout_reader #(
        .H_ACTIVE(H_ACT), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACT), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
        .FB_ROWS(FB_R), .FB_BASE(BASE1), .RD_LATENCY(1)
    ) u_l1 (
        .iCLK(clk), .iRST_N(rst_n), .iMEM_DATA(mem_data1), .iSHOW_DEPTH(show_depth),
        .oMEM_ADDR(addr1), .oMEM_READ(read1), .oVIDEO_ON(von1),
        .oVGA_R(r1), .oVGA_G(g1), .oVGA_B(b1), .oVGA_HS(hs1), .oVGA_VS(vs1),
        .oVGA_BLANK_N(bn1), .oFRAME_START(fs1)
    );

    fb_scanout_reader #(
        .H_ACTIVE(H_ACT), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACT), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
        .FB_ROWS(FB_R), .FB_BASE(BASE3), .RD_LATENCY(3)
    ) u_l3 (
        .iCLK(clk), .iRST_N(rst_n), .iMEM_DATA(mem_data3), .iSHOW_DEPTH(show_depth),
        .oMEM_ADDR(addr3), .oMEM_READ(read3), .oVIDEO_ON(von3),
        .oVGA_R(r3), .oVGA_G(g3), .oVGA_B(b3), .oVGA_HS(hs3), .oVGA_VS(vs3),
        .oVGA_BLANK_N(bn3), .oFRAME_START(fs3)
    );

    // ---------------- checking ----------------
    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model / scoreboard ----------------
    logic [W-1:0]  exp_q1[$];
    logic [W-1:0]  exp_q3[$];
    logic [19:0]   exp_mem1, exp_mem3;
    logic [17:0]   hold1, hold3;
    int            h_m, v_m, frame_m, since1, since3;
    logic          sd_m;
    logic          first_edge, prev_addr5, have_prev;
    int            cnt_hs, cnt_vs, cnt_rd, cnt_von3;

    function automatic logic [9:0] exp_color(input logic [3:0] c);
        logic [11:0] t;
        t = {c, c, c};
        return t[11:2];
    endfunction

    function automatic logic [9:0] exp_depth(input logic [1:0] d);
        return 10'(d) * 10'h155;
    endfunction

    function automatic logic [W-1:0] exp_pixel(input int h, input int v, input int base,
                                               input logic sd, input logic mode);
        logic [15:0] d;
        logic [9:0]  r, g, b;
        logic        fetch, hs, vs, bn, fs;
        fetch = (h < H_ACT) && (v < FB_R);
        d = mem_word(18'(base + v * H_ACT + h), mode);
        r = '0; g = '0; b = '0;
        if (fetch) begin
            if (sd) begin
                r = exp_depth(d[15:14]); g = r; b = r;
            end else begin
                r = exp_color(d[11:8]); g = exp_color(d[7:4]); b = exp_color(d[3:0]);
            end
        end
        hs = !((h >= H_ACT + H_FP) && (h < H_ACT + H_FP + H_SYNC));
        vs = !((v >= V_ACT + V_FP) && (v < V_ACT + V_FP + V_SYNC));
        bn = (h < H_ACT) && (v < V_ACT);
        fs = (h == 0) && (v == 0);
        return {r, g, b, hs, vs, bn, fs};
    endfunction

    task automatic model_reset();
        h_m = 0; v_m = 0; frame_m = 0;
        since1 = 99; since3 = 99;
        hold1 = '0; hold3 = '0;
        sd_m = 1'b0;
        first_edge = 1'b1; prev_addr5 = 1'b0; have_prev = 1'b0;
        cnt_hs = 0; cnt_vs = 0; cnt_rd = 0; cnt_von3 = 0;
        exp_q1.delete();
        exp_q3.delete();
        exp_q1.push_back(PIX_IDLE);
        repeat (3) exp_q3.push_back(PIX_IDLE);
    endtask

    // One clock edge of the model, from the raster position before the edge
    task automatic model_step();
        logic fetch;
        fetch = (h_m < H_ACT) && (v_m < FB_R);
        if (h_m == 0 && v_m == 0) sd_m = show_depth;
        if (fetch) begin
            hold1 = 18'(BASE1 + v_m * H_ACT + h_m);
            hold3 = 18'(BASE3 + v_m * H_ACT + h_m);
            since1 = 0;
            since3 = 0;
        end else begin
            if (since1 < 99) since1++;
            if (since3 < 99) since3++;
        end
        exp_mem1 = {fetch, hold1, since1 < 1};
        exp_mem3 = {fetch, hold3, since3 < 3};
        exp_q1.push_back(exp_pixel(h_m, v_m, BASE1, sd_m, data_mode));
        exp_q3.push_back(exp_pixel(h_m, v_m, BASE3, sd_m, data_mode));
        if (h_m == H_TOT - 1) begin
            h_m = 0;
            if (v_m == V_TOT - 1) begin
                v_m = 0;
                frame_m++;
            end else begin
                v_m++;
            end
        end else begin
            h_m++;
        end
    endtask

    task automatic compare_outputs();
        logic [W-1:0] e1, e3;
        e1 = (exp_q1.size() > 0) ? exp_q1.pop_front() : '0;
        e3 = (exp_q3.size() > 0) ? exp_q3.pop_front() : '0;
        check("mem_l1", 64'({read1, addr1, von1}), 64'(exp_mem1));
        check("mem_l3", 64'({read3, addr3, von3}), 64'(exp_mem3));
        check("pix_l1", 64'({r1, g1, b1, hs1, vs1, bn1, fs1}), 64'(e1));
        check("pix_l3", 64'({r3, g3, b3, hs3, vs3, bn3, fs3}), 64'(e3));
        if (first_edge) begin
            check("first_l1", 64'({read1, addr1, von1}), 64'({1'b1, 18'd0, 1'b1}));
            check("first_l3", 64'({read3, addr3, von3}), 64'({1'b1, 18'd100, 1'b1}));
            first_edge = 1'b0;
        end
        if (prev_addr5) begin
            check("addr5_rgb", 64'({r1, g1, b1, bn1}), 64'({10'h2AA, 10'h155, 10'h333, 1'b1}));
        end
        prev_addr5 = read1 && (addr1 == 18'd5) && !data_mode && !sd_m;
        if (fs1) begin
            if (have_prev) begin
                check("hs_low_frame", 64'(cnt_hs), 64'(H_SYNC * V_TOT));
                check("vs_low_frame", 64'(cnt_vs), 64'(V_SYNC * H_TOT));
                check("reads_frame", 64'(cnt_rd), 64'(H_ACT * FB_R));
                check("von_l3_frame", 64'(cnt_von3), 64'((H_ACT + 2) * FB_R));
            end
            have_prev = 1'b1;
            cnt_hs = 0; cnt_vs = 0; cnt_rd = 0; cnt_von3 = 0;
        end
        if (!hs1) cnt_hs++;
        if (!vs1) cnt_vs++;
        if (read1) cnt_rd++;
        if (von3) cnt_von3++;
    endtask

    // Monitor: step the model on every clock edge out of reset, compare 1 later
    initial begin
        forever begin
            @(posedge clk);
            if (rst_n === 1'b1) begin
                model_step();
                #1;
                compare_outputs();
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic check_reset(input string tag);
        check({tag, "_l1"}, 64'(all1), 64'(RST_VEC));
        check({tag, "_l3"}, 64'(all3), 64'(RST_VEC));
    endtask

    // Wait (at falling edges) until the raster model reaches frame f, line v, pixel h
    task automatic wait_pos(input int f, input int v, input int h);
        int n;
        n = 0;
        while (!(frame_m == f && v_m == v && h_m == h) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check("wait_pos", 64'(n < 5000), 64'(1));
    endtask

    initial begin
        rst_n = 1'b0;
        show_depth = 1'b0;
        data_mode = 1'b0;
        model_reset();
        repeat (5) @(negedge clk);
        check_reset("por");
        rst_n = 1'b1;

        // Frames 0-1: pattern data in color mode; switch data in frame 1 letterbox
        wait_pos(1, 9, 0);
        data_mode = 1'b1;

        // Depth mode requested mid-frame 2: not applied until frame 3
        wait_pos(2, 4, 0);
        show_depth = 1'b1;
        wait_pos(2, 5, 3);
        check("depth_deferred", 64'({r1, g1, b1}), 64'(30'd0));
        wait_pos(3, 1, 4);
        check("depth_on", 64'({r1, g1, b1}), 64'({10'h3FF, 10'h3FF, 10'h3FF}));

        // Asynchronous reset in the middle of a line
        wait_pos(3, 2, 9);
        #2;
        rst_n = 1'b0;
        model_reset();
        show_depth = 1'b0;
        data_mode = 1'b0;
        #1;
        check_reset("mid");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        wait_pos(2, 0, 0);
        repeat (10) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
